// File: rtl/reg_write_arbiter.sv
// RegFile write-port arbiter. WBU writes always win. Long-latency results wait in a
// small FIFO and drain into free slots, with a pending scoreboard and a starvation stall.
module reg_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int AW     = 2,
  parameter int STARVE = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_addr,
  input  logic [31:0]   pipe_data,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [4:0]    lu_addr,
  input  logic [31:0]   lu_data,
  input  logic          alloc_valid,
  input  logic [4:0]    alloc_addr,
  output logic          we,
  output logic [4:0]    wAddr,
  output logic [31:0]   wData,
  output logic [31:0]   pending,
  output logic          stall_req,
  output logic [AW:0]   q_count
);

  localparam int SW = $clog2(STARVE + 1);
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_W = SW'(STARVE);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [AW:0]   count_nxt;
  logic [31:0]   pending_nxt;
  logic          push, pop, pipe_issue, fifo_nempty;

  // Credit comes only from registered occupancy; a same-cycle pop does not free a slot.
  assign lu_ready    = !rst && (q_count < DEPTH_W);
  assign fifo_nempty = (q_count != '0);
  assign push        = lu_valid && lu_ready && (lu_addr != 5'd0);
  assign pipe_issue  = pipe_we && (pipe_addr != 5'd0);
  assign pop         = !pipe_issue && fifo_nempty;

  always_comb begin
    count_nxt = q_count;
    if (push && !pop)
      count_nxt = q_count + 1'b1;
    else if (pop && !push)
      count_nxt = q_count - 1'b1;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!fifo_nempty || pop)
      starve_nxt = '0;
    else if (starve_cnt != STARVE_W)
      starve_nxt = starve_cnt + 1'b1;
  end

  // Allocation is applied after the pop clear so a same-cycle set wins.
  always_comb begin
    pending_nxt = pending;
    if (pop)
      pending_nxt[fifo_addr[rd_ptr]] = 1'b0;
    if (alloc_valid && (alloc_addr != 5'd0))
      pending_nxt[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lu_addr;
      fifo_data[wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      q_count    <= '0;
      starve_cnt <= '0;
      we         <= 1'b0;
      wAddr      <= 5'd0;
      wData      <= 32'd0;
      pending    <= 32'd0;
      stall_req  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      q_count    <= count_nxt;
      starve_cnt <= starve_nxt;
      pending    <= pending_nxt;
      stall_req  <= (starve_nxt == STARVE_W) && (count_nxt != '0);
      if (pipe_issue) begin
        we    <= 1'b1;
        wAddr <= pipe_addr;
        wData <= pipe_data;
      end else if (pop) begin
        we    <= 1'b1;
        wAddr <= fifo_addr[rd_ptr];
        wData <= fifo_data[rd_ptr];
      end else begin
        we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Drives the single RegFile write port (we/wAddr/wData) on behalf of every result producer.
- The in-order WBU writeback path always gets through.
- Long-latency results (mul/div, multi-cycle loads) are queued in a small FIFO and drained on cycles the WBU leaves free.
- Keeps a 32-bit pending scoreboard so IDU can hold dependent reads until the queued result has landed.

Parameters:
DEPTH, 4, long-latency FIFO entries (power of two, >=2)
AW, 2, log2(DEPTH)
STARVE, 8, consecutive un-drained cycles with a non-empty FIFO before stall_req asserts

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
pipe_we  in  1  WBU write request; never back-pressured
pipe_addr  in  5  WBU destination register
pipe_data  in  32  WBU write data
lu_valid  in  1  long-latency result valid
lu_ready  out  1  FIFO can accept; transfer when lu_valid && lu_ready
lu_addr  in  5  long-latency destination register
lu_data  in  32  long-latency result
alloc_valid  in  1  IDU issued a long-latency op this cycle
alloc_addr  in  5  destination of that op
we  out  1  RegFile write enable (registered)
wAddr  out  5  RegFile write address (registered)
wData  out  32  RegFile write data (registered)
pending  out  32  bit n = register n awaits a long-latency result (registered)
stall_req  out  1  asks IDU to insert a bubble so the FIFO can drain (registered)
q_count  out  AW+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async, rst=1):
  - Output values: we=0, wAddr=0, wData=0, pending=0, stall_req=0, q_count=0.
  - FIFO pointers are cleared and the starvation counter is cleared.
  - lu_ready=0 while rst=1; an in-flight FIFO entry is lost.
- lu_ready = !rst && (q_count < DEPTH). It is combinational from registered state; a same-cycle pop gives no credit.
- Push: lu_valid && lu_ready && lu_addr!=0 enqueues {lu_addr, lu_data} at the tail.
  - A handshake with lu_addr==0 completes (is consumed) but nothing is enqueued.
- Issue selection, evaluated each cycle; the chosen write appears on we/wAddr/wData at the next edge (1-cycle latency):
  1. pipe_we && pipe_addr!=0: issue the pipe write.
  2. else, if the FIFO is non-empty: pop the head and issue it.
  3. else: we=0. wAddr/wData hold their previous values.
- pipe_we with pipe_addr==0 is dropped and counts as a free slot, so the FIFO may pop that cycle. r0 is never written.
- Push and pop in the same cycle: q_count is unchanged.
- Pointers wrap modulo DEPTH.
- Pending scoreboard:
  - Set bit alloc_addr on alloc_valid && alloc_addr!=0.
  - Clear bit a when a FIFO entry with address a is popped.
  - Set and clear of the same bit in the same cycle: set wins.
  - pipe writes never touch pending.
  - IDU guarantees at most one outstanding long-latency op per register. An alloc on an already-set bit leaves it set.
- Starvation counter, saturating at STARVE:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - stall_req <= (counter == STARVE) && FIFO non-empty.
  - stall_req drops the cycle after the first pop.
- Per-cycle accounting: at most one push, one pop and one RegFile write.

Test Plan:
- Reset: assert rst mid-operation with q_count=3 -> we=0, pending=0, q_count=0, lu_ready=0 immediately; lu_ready=1 on the first cycle after release.
- Pipe priority: pipe_we=1 addr 5 data 0x1234 every cycle while lu pushes addr 7 data 0xBEEF.
  - Next-cycle we=1, wAddr=5, wData=0x1234.
  - FIFO holds 0xBEEF; q_count rises to 1.
- Drain and scoreboard: alloc addr 9; three cycles later lu push addr 9 data 0xCAFE with pipe idle.
  - pending[9]=1 from the cycle after alloc.
  - FIFO drains the cycle after the push: we=1, wAddr=9, wData=0xCAFE.
  - pending[9]=0 on the same edge.
- Full/back-pressure: hold pipe_we=1 and push 5 lu results -> lu_ready=0 after the 4th (q_count=4); the 5th is held until a pop.
- Starvation: FIFO non-empty, pipe_we=1 continuously.
  - stall_req=1 after 8 blocked cycles.
  - Drop pipe_we for one cycle -> pop occurs, stall_req=0 the following cycle.
- r0 handling: pipe_we addr 0, lu push addr 0, alloc addr 0 -> no RegFile write; pending stays 0; q_count stays 0.
